// File: rtl/bcd_counter_pkg.sv
// Shared types and helpers for the N-digit BCD counter and its 7-segment decoder.
package bcd_counter_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam bcd_t BCD_MAX   = 4'd9;
  localparam seg_t SEG_BLANK = 7'h7F;

  // Non-decimal nibbles are forced to zero on load.
  function automatic bcd_t bcd_sanitize(input bcd_t v);
    return (v > BCD_MAX) ? 4'd0 : v;
  endfunction

endpackage

// File: rtl/seg7_bcd_decoder.sv
// Active-low {g..a} 7-segment decoder for one BCD digit, with blank control.
module seg7_bcd_decoder
  import bcd_counter_pkg::*;
(
  input  bcd_t bcd_i,
  input  logic blank_i,
  output seg_t seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank_i) begin
      unique case (bcd_i)
        4'd0:    seg_c = 7'b1000000;
        4'd1:    seg_c = 7'b1111001;
        4'd2:    seg_c = 7'b0100100;
        4'd3:    seg_c = 7'b0110000;
        4'd4:    seg_c = 7'b0011001;
        4'd5:    seg_c = 7'b0010010;
        4'd6:    seg_c = 7'b0000010;
        4'd7:    seg_c = 7'b1111000;
        4'd8:    seg_c = 7'b0000000;
        4'd9:    seg_c = 7'b0010000;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with prescaler, rate select, load, wrap/saturate.
// Optional LEADING_ZERO_BLANK_EN blanks segment patterns above the highest nonzero digit.
module bcd_counter_n
  import bcd_counter_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned RATE_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  dir_i,
  input  logic [RATE_W-1:0]     rate_i,
  input  logic                  sat_i,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  output logic [4*DIGITS-1:0]   digits_o,
  output logic [7*DIGITS-1:0]   seg_o,
  output logic                  tick_o,
  output logic                  carry_o,
  output logic                  ovf_o
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  localparam int unsigned VAL_W   = 4 * DIGITS;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [VAL_W-1:0]   digits_q, digits_d;
  logic               tick_q, tick_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;

  logic [31:0]        term_c;
  logic               tick_c;
  logic [VAL_W-1:0]   stepped_c;
  logic [VAL_W-1:0]   loaded_c;
  logic               at_lim_c;
  logic [DIGITS-1:0]  blank_c;

  // Terminal test uses >= so a rate change past the new terminal ticks at once.
  always_comb begin
    term_c = 32'(TICK_DIV) >> rate_i;
    tick_c = en_i && ((32'(presc_q) + 32'd1) >= term_c);
  end

  // Ripple step: a digit moves only while every lower digit sits at its limit.
  always_comb begin
    bcd_t d;
    stepped_c = digits_q;
    loaded_c  = '0;
    at_lim_c  = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = digits_q[4*k +: 4];
      if (at_lim_c) begin
        if (!dir_i) stepped_c[4*k +: 4] = (d == BCD_MAX) ? 4'd0 : d + 4'd1;
        else        stepped_c[4*k +: 4] = (d == 4'd0) ? BCD_MAX : d - 4'd1;
      end
      at_lim_c = at_lim_c && (dir_i ? (d == 4'd0) : (d == BCD_MAX));
      loaded_c[4*k +: 4] = bcd_sanitize(load_val_i[4*k +: 4]);
    end
  end

  always_comb begin
    presc_d  = presc_q;
    digits_d = digits_q;
    tick_d   = 1'b0;
    carry_d  = 1'b0;
    ovf_d    = ovf_q;
    if (clr_i) begin
      presc_d  = '0;
      digits_d = '0;
      ovf_d    = 1'b0;
    end else if (load_i) begin
      presc_d  = '0;
      digits_d = loaded_c;
    end else if (tick_c) begin
      presc_d = '0;
      tick_d  = 1'b1;
      if (at_lim_c && sat_i) begin
        ovf_d = 1'b1;
      end else begin
        digits_d = stepped_c;
        carry_d  = at_lim_c;
      end
    end else if (en_i) begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      digits_q <= '0;
      tick_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      digits_q <= digits_d;
      tick_q   <= tick_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank digit k when it and every digit above it are zero; digit 0 always lit.
  always_comb begin
    logic upper_zero;
    blank_c    = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (digits_q[4*k +: 4] == 4'd0);
      blank_c[k] = upper_zero;
    end
  end
`else
  always_comb begin
    blank_c = '0;
  end
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    seg7_bcd_decoder u_dec (
      .bcd_i   (digits_q[4*k +: 4]),
      .blank_i (blank_c[k]),
      .seg_c   (seg_o[7*k +: 7])
    );
  end

  assign digits_o = digits_q;
  assign tick_o   = tick_q;
  assign carry_o  = carry_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench for bcd_counter_n: integer-valued reference model plus directed checks.
module tb_bcd_counter_n;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned TICK_DIV = 8;
  localparam int unsigned RATE_W   = 2;
  localparam int          MAXV     = 9999;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en_i = 1'b1;
  logic              dir_i = 1'b0;
  logic [RATE_W-1:0] rate_i = '0;
  logic              sat_i = 1'b0;
  logic              clr_i = 1'b0;
  logic              load_i = 1'b0;
  logic [15:0]       load_val_i = '0;
  logic [15:0]       digits_o;
  logic [27:0]       seg_o;
  logic              tick_o, carry_o, ovf_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .RATE_W(RATE_W)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .dir_i(dir_i), .rate_i(rate_i),
    .sat_i(sat_i), .clr_i(clr_i), .load_i(load_i), .load_val_i(load_val_i),
    .digits_o(digits_o), .seg_o(seg_o), .tick_o(tick_o), .carry_o(carry_o), .ovf_o(ovf_o)
  );

  localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] m_bcd(int v);
    logic [15:0] r = '0;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [27:0] m_seg(int v);
    logic [27:0] r = '0;
    logic [6:0]  s;
    int p = 1;
    for (int k = 0; k < 4; k++) begin
      s = PAT[(v / p) % 10];
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && v < p) s = 7'h7F;
`endif
      r[7*k +: 7] = s;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int m_load(logic [15:0] lv);
    int v = 0;
    int p = 1;
    for (int k = 0; k < 4; k++) begin
      if (lv[4*k +: 4] <= 4'd9) v = v + int'(lv[4*k +: 4]) * p;
      p = p * 10;
    end
    return v;
  endfunction

  // Reference model: counter value as a plain integer, prescaler as a cycle count.
  int m_val = 0, m_presc = 0;
  bit m_tick = 0, m_carry = 0, m_ovf = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val = 0; m_presc = 0; m_tick = 0; m_carry = 0; m_ovf = 0;
    end else begin
      m_tick = 0;
      m_carry = 0;
      if (clr_i) begin
        m_val = 0; m_presc = 0; m_ovf = 0;
      end else if (load_i) begin
        m_val = m_load(load_val_i);
        m_presc = 0;
      end else if (en_i) begin
        if (m_presc + 1 >= int'(TICK_DIV >> rate_i)) begin
          m_presc = 0;
          m_tick = 1;
          if (!dir_i) begin
            if (m_val == MAXV) begin
              if (sat_i) m_ovf = 1; else begin m_val = 0; m_carry = 1; end
            end else m_val = m_val + 1;
          end else begin
            if (m_val == 0) begin
              if (sat_i) m_ovf = 1; else begin m_val = MAXV; m_carry = 1; end
            end else m_val = m_val - 1;
          end
        end else begin
          m_presc = m_presc + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_digits", 32'(digits_o), 32'(m_bcd(m_val)));
    chk("m_seg",    32'(seg_o),    32'(m_seg(m_val)));
    chk("m_tick",   32'(tick_o),   32'(m_tick));
    chk("m_carry",  32'(carry_o),  32'(m_carry));
    chk("m_ovf",    32'(ovf_o),    32'(m_ovf));
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      cyc(1);
      n++;
    end while (!tick_o && n < 20);
    chk("tick_timeout", 32'(tick_o), 32'd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cyc(2);
    chk("rst_digits", 32'(digits_o), 32'h0);
    chk("rst_tick",   32'(tick_o), 32'd0);
    chk("rst_ovf",    32'(ovf_o), 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
    chk("rst_seg", 32'(seg_o), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
`else
    chk("rst_seg", 32'(seg_o), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
`endif
    rst_n = 1'b1;

    // Up count at 1x: first tick after 8 clocks.
    cyc(8);
    chk("first_tick", 32'(tick_o), 32'd1);
    chk("first_val",  32'(digits_o), 32'h0001);
    cyc(64);
    chk("val_0009", 32'(digits_o), 32'h0009);
    cyc(8);
    chk("val_0010", 32'(digits_o), 32'h0010);
    chk("seg_d1_1", 32'(seg_o[13:7]), 32'h79);
    chk("seg_d0_0", 32'(seg_o[6:0]), 32'h40);

    // Wrap from 9999 with a single-cycle carry.
    load_i = 1'b1; load_val_i = 16'h9998;
    cyc(1);
    load_i = 1'b0;
    chk("load_9998", 32'(digits_o), 32'h9998);
    wait_tick();
    chk("val_9999", 32'(digits_o), 32'h9999);
    wait_tick();
    chk("wrap_val",   32'(digits_o), 32'h0000);
    chk("wrap_carry", 32'(carry_o), 32'd1);
    chk("wrap_ovf",   32'(ovf_o), 32'd0);
    cyc(1);
    chk("carry_pulse", 32'(carry_o), 32'd0);

    // Saturate going down from 0001.
    load_i = 1'b1; load_val_i = 16'h0001; dir_i = 1'b1; sat_i = 1'b1;
    cyc(1);
    load_i = 1'b0;
    wait_tick();
    chk("down_0000", 32'(digits_o), 32'h0000);
    chk("down_ovf0", 32'(ovf_o), 32'd0);
    wait_tick();
    chk("sat_hold",  32'(digits_o), 32'h0000);
    chk("sat_ovf",   32'(ovf_o), 32'd1);
    chk("sat_carry", 32'(carry_o), 32'd0);
    cyc(3);
    chk("ovf_sticky", 32'(ovf_o), 32'd1);
    clr_i = 1'b1;
    cyc(1);
    clr_i = 1'b0; dir_i = 1'b0; sat_i = 1'b0;
    chk("clr_ovf", 32'(ovf_o), 32'd0);
    chk("clr_val", 32'(digits_o), 32'h0000);

    // Rate jump to 8x with the prescaler at 6.
    cyc(6);
    rate_i = 2'd3;
    cyc(1);
    chk("rate_tick", 32'(tick_o), 32'd1);
    chk("rate_val",  32'(digits_o), 32'h0001);
    cyc(2);
    chk("rate_fast", 32'(digits_o), 32'h0003);
    en_i = 1'b0;
    cyc(3);
    chk("pause_val",  32'(digits_o), 32'h0003);
    chk("pause_tick", 32'(tick_o), 32'd0);
    en_i = 1'b1;
    cyc(1);
    chk("resume_val", 32'(digits_o), 32'h0004);
    rate_i = 2'd0;
    cyc(4);
    en_i = 1'b0;
    cyc(5);
    en_i = 1'b1;
    cyc(3);
    chk("frz_notick", 32'(tick_o), 32'd0);
    cyc(1);
    chk("frz_tick", 32'(tick_o), 32'd1);
    chk("frz_val",  32'(digits_o), 32'h0005);

    // Load coincident with a tick; sanitized nibble.
    cyc(7);
    load_i = 1'b1; load_val_i = 16'h00A5;
    cyc(1);
    load_i = 1'b0;
    chk("ldtick_val",   32'(digits_o), 32'h0005);
    chk("ldtick_tick",  32'(tick_o), 32'd0);
    chk("ldtick_carry", 32'(carry_o), 32'd0);

    // Asynchronous reset between edges.
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_val",   32'(digits_o), 32'h0);
    chk("arst_tick",  32'(tick_o), 32'd0);
    chk("arst_carry", 32'(carry_o), 32'd0);
    chk("arst_ovf",   32'(ovf_o), 32'd0);
    cyc(1);
    rst_n = 1'b1;

    // Leading-zero display.
    load_i = 1'b1; load_val_i = 16'h0040;
    cyc(1);
    load_i = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_0040", 32'(seg_o), 32'({7'h7F, 7'h7F, 7'h19, 7'h40}));
`else
    chk("lz_0040", 32'(seg_o), 32'({7'h40, 7'h40, 7'h19, 7'h40}));
`endif
    clr_i = 1'b1;
    cyc(1);
    clr_i = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_0000", 32'(seg_o), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
`else
    chk("lz_0000", 32'(seg_o), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
`endif
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
